// File: rtl/button_debounce_sync.sv
// Pushbutton / switch input conditioner.
//
// Brings a raw, asynchronous, possibly bouncing level into the clk domain through a
// two-flop synchroniser. The synchronised level must then hold a new value for
// STABLE_CNT+1 consecutive FSM samples (STABLE_CNT counted cycles after the first)
// before the clean output q follows it. Any return to the old value restarts the count.
//
// Ports:
//   clk  - system clock, all state updates on the rising edge
//   rst  - asynchronous active-high reset, clears every flop immediately
//   d    - raw asynchronous input level (may glitch or bounce)
//   q    - debounced level (registered)
//   rise - one-cycle pulse in the cycle q goes 0->1 (registered)
//   fall - one-cycle pulse in the cycle q goes 1->0 (registered)
//
// Parameters:
//   STABLE_CNT - cycles a new level must be held before acceptance (2 .. 2**CNT_WIDTH)
//   CNT_WIDTH  - width of the stability counter, must hold STABLE_CNT-1
module button_debounce_sync #(
  parameter int unsigned STABLE_CNT = 50000,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  typedef enum logic [1:0] {
    StStableLo,
    StWaitHi,
    StStableHi,
    StWaitLo
  } state_e;

  // Terminal count; the exit test happens before the increment so cnt_q never wraps.
  localparam logic [CNT_WIDTH-1:0] CntLast = CNT_WIDTH'(STABLE_CNT - 1);

  logic                 sync1_q;
  logic                 sync2_q;
  state_e               state_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 q_q;
  logic                 rise_q;
  logic                 fall_q;

  // Two-flop synchroniser; only sync2_q is ever looked at by the filter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= d;
      sync2_q <= sync1_q;
    end
  end

  // Debounce FSM with registered level and edge pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StStableLo;
      cnt_q   <= '0;
      q_q     <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      // Pulses last exactly one cycle unless re-asserted below.
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      unique case (state_q)
        StStableLo: begin
          cnt_q <= '0;
          if (sync2_q) begin
            state_q <= StWaitHi;
          end
        end
        StWaitHi: begin
          if (!sync2_q) begin
            // Bounce: discard progress, q untouched.
            state_q <= StStableLo;
            cnt_q   <= '0;
          end else if (cnt_q == CntLast) begin
            state_q <= StStableHi;
            cnt_q   <= '0;
            q_q     <= 1'b1;
            rise_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StStableHi: begin
          cnt_q <= '0;
          if (!sync2_q) begin
            state_q <= StWaitLo;
          end
        end
        StWaitLo: begin
          if (sync2_q) begin
            state_q <= StStableHi;
            cnt_q   <= '0;
          end else if (cnt_q == CntLast) begin
            state_q <= StStableLo;
            cnt_q   <= '0;
            q_q     <= 1'b0;
            fall_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= StStableLo;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign q    = q_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: tb/tb_button_debounce_sync.sv
module tb_button_debounce_sync;

  localparam int unsigned S = 4;

  logic clk = 1'b0;
  logic rst;
  logic d;
  logic q;
  logic rise;
  logic fall;

  int total = 0;
  int bad   = 0;

  button_debounce_sync #(
    .STABLE_CNT(S),
    .CNT_WIDTH (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .d   (d),
    .q   (q),
    .rise(rise),
    .fall(fall)
  );

  always #5 clk = ~clk;

  // Reference model: the filter input is d as sampled two edges earlier; q flips once
  // S+1 consecutive filter samples since the last change all differ from q.
  bit m_pipe[2];
  int m_run;
  bit m_q, m_rise, m_fall;

  task automatic model_reset();
    m_pipe[0] = 1'b0;
    m_pipe[1] = 1'b0;
    m_run     = 0;
    m_q       = 1'b0;
    m_rise    = 1'b0;
    m_fall    = 1'b0;
  endtask

  task automatic model_edge();
    bit s;
    s         = m_pipe[0];
    m_pipe[0] = m_pipe[1];
    m_pipe[1] = d;
    m_rise    = 1'b0;
    m_fall    = 1'b0;
    if (s != m_q) begin
      m_run++;
      if (m_run == S + 1) begin
        m_q    = s;
        m_rise = s;
        m_fall = !s;
        m_run  = 0;
      end
    end else begin
      m_run = 0;
    end
  endtask

  // One clock edge; inputs are stable here since they only change 1ns after an edge.
  task automatic tick();
    if (rst) model_reset();
    else model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic eq, input logic er, input logic ef);
    total++;
    if ({q, rise, fall} !== {eq, er, ef}) begin
      bad++;
      $display("FAIL %s at %0t: q/rise/fall got %b%b%b expected %b%b%b",
               name, $time, q, rise, fall, eq, er, ef);
    end
  endtask

  typedef struct {
    logic rst;
    logic d;
    logic eq;
    logic er;
    logic ef;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic dd, input logic eq, input logic er,
                     input logic ef, input int n);
    vec_t v;
    v.rst = r; v.d = dd; v.eq = eq; v.er = er; v.ef = ef;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  initial begin
    bit bounce[8];
    int run_left;

    // Reset held with d=1; outputs must be low before any clock edge.
    rst = 1'b1;
    d   = 1'b1;
    model_reset();
    #2;
    check("async_reset_pre_clk", 1'b0, 1'b0, 1'b0);

    // Table: reset, clean press, clean release.
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6);
    add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3);
    // First two rows apply during the pre-clock reset window.
    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst;
      d   = vecs[i].d;
      tick();
      check("table", vecs[i].eq, vecs[i].er, vecs[i].ef);
    end

    // Bounce 1,0,1,0 (2 cycles each), then hold 1: one rise, 7 edges after final rise.
    bounce = '{1, 1, 0, 0, 1, 1, 0, 0};
    for (int i = 0; i < 8; i++) begin
      d = bounce[i];
      tick();
      check("bounce_hold_low", 1'b0, 1'b0, 1'b0);
    end
    d = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      check("bounce_settle", (i >= 7), (i == 7), 1'b0);
    end

    // 3-cycle low glitch while q=1 must be ignored.
    d = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("glitch_low", 1'b1, 1'b0, 1'b0);
    end
    d = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("glitch_recover", 1'b1, 1'b0, 1'b0);
    end

    // Release, then reset in the middle of a press count.
    d = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("release", (i < 7), 1'b0, (i == 7));
    end
    d = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("press_before_rst", 1'b0, 1'b0, 1'b0);
    end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_mid_count_async", 1'b0, 1'b0, 1'b0);
    tick();
    check("rst_mid_count_held", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      check("press_after_rst", (i >= 7), (i == 7), 1'b0);
    end

    // Randomised runs of d against the reference model, with occasional resets.
    run_left = 0;
    for (int n = 0; n < 3000; n++) begin
      if (run_left == 0) begin
        d        = $urandom_range(0, 1);
        run_left = $urandom_range(1, 9);
      end
      run_left--;
      rst = ($urandom_range(0, 299) == 0);
      tick();
      check("random", m_q, m_rise, m_fall);
      if (rise && fall) begin
        total++;
        bad++;
        $display("FAIL rise_fall_together at %0t: got 11 expected not both", $time);
      end
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
